// File: rtl/ram_access_controller_pkg.sv
// Shared widths, FSM states, port indices and the RAM command payload.
package ram_access_controller_pkg;

  localparam int unsigned ADDR_W           = 9;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned STARVE_W         = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_cmd_t;

endpackage

// File: rtl/ram_access_controller_arb_pick.sv
// Grant selection between fetch and data ports with a fetch starvation counter.
module ram_access_controller_arb_pick
  import ram_access_controller_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic sample_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic grant_valid_c,
  output logic grant_port_c
);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                starved;

  // Data wins unless fetch has waited through STARVE_LIMIT data grants.
  always_comb begin
    starved       = if_req_i && (starve_q == STARVE_W'(STARVE_LIMIT));
    grant_valid_c = sample_i && (if_req_i || d_req_i);
    grant_port_c  = (d_req_i && !starved) ? PORT_D : PORT_IF;
    starve_d      = starve_q;
    if (grant_valid_c) begin
      if ((grant_port_c == PORT_D) && if_req_i) begin
        starve_d = starve_q + STARVE_W'(1);
      end else begin
        starve_d = '0;
      end
    end else if (idle_i && !if_req_i) begin
      starve_d = '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/ram_access_controller.sv
// Sequences the single-port RAM for a fetch port and a data port.
module ram_access_controller
  import ram_access_controller_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              busy,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_e            state_q;
  ram_cmd_t          cmd_q;
  logic              port_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              if_ack_q, d_ack_q, busy_q;
  logic              idle, sample;
  logic              grant_valid_c, grant_port_c;

  // Requests in the ack cycle belong to the finishing transaction, so skip sampling.
  assign idle   = (state_q == ST_IDLE);
  assign sample = idle && !(if_ack_q || d_ack_q);

  ram_access_controller_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk          (clock),
    .rst_n        (clear_n),
    .idle_i       (idle),
    .sample_i     (sample),
    .if_req_i     (if_req),
    .d_req_i      (d_req),
    .grant_valid_c(grant_valid_c),
    .grant_port_c (grant_port_c)
  );

  // Transaction FSM with registered RAM command, read data and acks.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= ST_IDLE;
      port_q     <= PORT_IF;
      cmd_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid_c) begin
            port_q  <= grant_port_c;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
            if (grant_port_c == PORT_D) begin
              cmd_q.rd    <= ~d_we;
              cmd_q.wr    <= d_we;
              cmd_q.addr  <= d_addr;
              cmd_q.wdata <= d_wdata;
            end else begin
              cmd_q.rd   <= 1'b1;
              cmd_q.wr   <= 1'b0;
              cmd_q.addr <= if_addr;
            end
          end
        end
        ST_ISSUE: begin
          cmd_q.rd <= 1'b0;
          cmd_q.wr <= 1'b0;
          state_q  <= cmd_q.wr ? ST_ACK : ST_WAIT;
        end
        ST_WAIT: begin
          if (port_q == PORT_D) begin
            d_rdata_q <= ram_data_out;
          end else begin
            if_rdata_q <= ram_data_out;
          end
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          if (port_q == PORT_D) begin
            d_ack_q <= 1'b1;
          end else begin
            if_ack_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_read    = cmd_q.rd;
  assign ram_write   = cmd_q.wr;
  assign ram_address = cmd_q.addr;
  assign ram_data_in = cmd_q.wdata;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ram_access_controller.sv
// Randomized and directed checks of ram_access_controller against a transaction-level model.
module tb_ram_access_controller;
  import ram_access_controller_pkg::*;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        if_req, d_req, d_we;
  logic [8:0]  if_addr, d_addr;
  logic [31:0] d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_ack, d_ack, busy;
  logic        ram_read, ram_write;
  logic [8:0]  ram_address;
  logic [31:0] ram_data_in, ram_data_out;

  always #5 clock = ~clock;

  ram_access_controller #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .clear_n(clear_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .busy(busy),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 16) return 32'h12345678;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // 512x32 RAM: registered address, data valid the cycle after capture.
  logic [31:0] ram_mem [512];
  logic [31:0] ram_dout = '0;
  bit          ram_loaded = 1'b0;
  assign ram_data_out = ram_dout;
  always @(posedge clock) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 512; i++) ram_mem[i] = init_val(i);
      ram_loaded = 1'b1;
    end
    if (ram_write) ram_mem[ram_address] = ram_data_in;
    if (ram_read) ram_dout <= ram_mem[ram_address];
  end

  // Reference model state: one outstanding transaction, timed by cycle arithmetic.
  int          n = 0, free_at = 0, g_cycle = 0, ack_cycle = 0, m_starve = 0;
  int          total = 0, passed = 0;
  bit          pend = 1'b0, p_we = 1'b0;
  logic        p_port = 1'b0;
  logic [8:0]  p_addr = '0;
  logic [31:0] p_wdata = '0, exp_ifr = '0, exp_dr = '0;
  logic [31:0] shadow [512];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
  endtask

  // Decide what the controller does with the inputs present in cycle n.
  task automatic model_eval();
    bit win_d;
    if (!clear_n) begin
      pend = 1'b0; free_at = n + 1; m_starve = 0; exp_ifr = '0; exp_dr = '0;
      return;
    end
    if (n >= free_at - 1 && !if_req) m_starve = 0;
    if (n >= free_at && (if_req || d_req)) begin
      win_d = d_req && !(if_req && m_starve == LIMIT);
      if (!win_d) m_starve = 0;
      else if (if_req) m_starve++;
      pend      = 1'b1;
      p_port    = win_d ? PORT_D : PORT_IF;
      p_we      = win_d && d_we;
      p_addr    = win_d ? d_addr : if_addr;
      p_wdata   = d_wdata;
      g_cycle   = n;
      ack_cycle = n + (p_we ? 3 : 4);
      free_at   = ack_cycle + 1;
    end
  endtask

  // Compare every output in cycle n against the model.
  task automatic compare();
    logic e_ifa, e_da, e_busy, e_rr, e_rw;
    if (pend && !p_we && n == ack_cycle - 1) begin
      if (p_port == PORT_D) exp_dr = shadow[p_addr];
      else exp_ifr = shadow[p_addr];
    end
    if (pend && p_we && n == g_cycle + 2) shadow[p_addr] = p_wdata;
    e_ifa  = pend && n == ack_cycle && p_port == PORT_IF;
    e_da   = pend && n == ack_cycle && p_port == PORT_D;
    e_busy = pend && n > g_cycle && n < ack_cycle;
    e_rr   = pend && n == g_cycle + 1 && !p_we;
    e_rw   = pend && n == g_cycle + 1 && p_we;
    chk("if_ack", 32'(if_ack), 32'(e_ifa));
    chk("d_ack", 32'(d_ack), 32'(e_da));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("ram_read", 32'(ram_read), 32'(e_rr));
    chk("ram_write", 32'(ram_write), 32'(e_rw));
    chk("if_rdata", if_rdata, exp_ifr);
    chk("d_rdata", d_rdata, exp_dr);
    if (pend && n == g_cycle + 1) begin
      chk("ram_address", 32'(ram_address), 32'(p_addr));
      if (p_we) chk("ram_data_in", ram_data_in, p_wdata);
    end
    if (pend && n == ack_cycle) pend = 1'b0;
  endtask

  // One clock: model consumes inputs, DUT clocks, outputs compared; requesters drop on ack.
  task automatic tick();
    model_eval();
    @(posedge clock);
    #1;
    n++;
    compare();
    if (if_ack) if_req = 1'b0;
    if (d_ack) d_req = 1'b0;
  endtask

  task automatic run_txn(input logic port, input logic we, input logic [8:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rdata, output int bcnt);
    int c0;
    bit done;
    done = 1'b0; bcnt = 0; lat = -1; rdata = '0;
    if (port == PORT_D) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    c0 = n;
    for (int k = 0; k < 12 && !done; k++) begin
      tick();
      if (busy) bcnt++;
      if ((port == PORT_D) ? d_ack : if_ack) begin
        done  = 1'b1;
        lat   = n - c0;
        rdata = (port == PORT_D) ? d_rdata : if_rdata;
      end
    end
    if (!done) begin
      chk("txn_timeout", 32'd0, 32'd1);
      if_req = 1'b0; d_req = 1'b0;
    end
    tick();
  endtask

  function automatic logic [8:0] pick_addr();
    logic [8:0] pool [6];
    pool = '{9'h000, 9'h001, 9'h0AA, 9'h1FF, 9'h1F0, 9'h010};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 5)];
    return 9'($urandom);
  endfunction

  initial begin
    int          lat, bcnt, cnt, guard, first_if;
    logic [31:0] rd;
    bit          ack_seen;
    int          got [6];
    int          exp_ord [6];
    exp_ord = '{1, 1, 1, 1, 0, 1};

    for (int i = 0; i < 512; i++) shadow[i] = init_val(i);
    clear_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;

    // Reset state.
    repeat (3) tick();
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_ram_data_in", ram_data_in, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    clear_n = 1'b1;
    tick();

    // Reset during ISSUE of a store abandons it.
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h1F0; d_wdata = 32'hDEADBEEF;
    tick();
    chk("t1_issue_write", 32'(ram_write), 32'd1);
    clear_n = 1'b0;
    #1;
    chk("t1_async_write", 32'(ram_write), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    d_req = 1'b0;
    ack_seen = 1'b0;
    repeat (2) begin tick(); if (d_ack) ack_seen = 1'b1; end
    clear_n = 1'b1;
    repeat (5) begin tick(); if (d_ack) ack_seen = 1'b1; end
    chk("t1_mem_unchanged", ram_mem[9'h1F0], init_val(32'h1F0));
    chk("t1_no_ack", 32'(ack_seen), 32'd0);

    // Lone fetch.
    run_txn(PORT_IF, 1'b0, 9'h010, 32'h0, lat, rd, bcnt);
    chk("t2_latency", 32'(lat), 32'd4);
    chk("t2_rdata", rd, 32'h12345678);
    chk("t2_busy_cycles", 32'(bcnt), 32'd3);

    // Store then load.
    run_txn(PORT_D, 1'b1, 9'h0AA, 32'hCAFEF00D, lat, rd, bcnt);
    chk("t3_store_latency", 32'(lat), 32'd3);
    chk("t3_store_busy", 32'(bcnt), 32'd2);
    run_txn(PORT_D, 1'b0, 9'h0AA, 32'h0, lat, rd, bcnt);
    chk("t3_load_latency", 32'(lat), 32'd4);
    chk("t3_load_rdata", rd, 32'hCAFEF00D);

    // Address extremes.
    run_txn(PORT_D, 1'b1, 9'h1FF, 32'hA5A5A5A5, lat, rd, bcnt);
    run_txn(PORT_D, 1'b1, 9'h000, 32'h5A5A5A5A, lat, rd, bcnt);
    run_txn(PORT_D, 1'b0, 9'h1FF, 32'h0, lat, rd, bcnt);
    chk("t6_rd_1ff", rd, 32'hA5A5A5A5);
    run_txn(PORT_IF, 1'b0, 9'h000, 32'h0, lat, rd, bcnt);
    chk("t6_rd_000", rd, 32'h5A5A5A5A);

    // Both ports held: fetch gets a grant after STARVE_LIMIT data grants.
    if_addr = 9'h010; d_addr = 9'h0AA; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    cnt = 0; guard = 0; first_if = -1;
    while (cnt < 6 && guard < 80) begin
      tick();
      guard++;
      if (if_ack && cnt < 6) begin
        if (first_if < 0) first_if = cnt;
        got[cnt] = 0; cnt++;
      end
      if (d_ack && cnt < 6) begin got[cnt] = 1; cnt++; end
      if (!if_req && !if_ack) if_req = 1'b1;
      if (!d_req && !d_ack) d_req = 1'b1;
    end
    if (cnt < 6) chk("t4_timeout", 32'(cnt), 32'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("t4_order_%0d", k), 32'(got[k]), 32'(exp_ord[k]));
    chk("t5_first_fetch_grant", 32'(first_if), 32'd4);
    if_req = 1'b0; d_req = 1'b0;
    repeat (10) tick();

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i == 1500) clear_n = 1'b0;
      if (i == 1503) clear_n = 1'b1;
      if (!if_req && !if_ack) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = pick_addr(); end
      end else if (if_req && $urandom_range(0, 63) == 0) if_req = 1'b0;
      if (!d_req && !d_ack) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
          d_addr = pick_addr(); d_wdata = $urandom;
        end
      end else if (d_req && $urandom_range(0, 63) == 0) d_req = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
